// File: rtl/pulse_capture.sv
// pulse_capture: measures the high-time of each pulse on pulse_in, in clock
// cycles, and queues the widths in a small show-ahead FIFO.
// Optional feature: define PULSE_CAPTURE_SYNC_EN to pass pulse_in through a
// 2-flop synchronizer (2 cycles extra latency, widths unchanged).
// Ports:
//   clk          single clock
//   reset        asynchronous, active-high; clears all state
//   start        arm a measurement run (from IDLE or DONE)
//   stop         abort run, return to IDLE (wins over start)
//   pulse_in     pulse under measurement
//   width_data   FIFO head (measured width)
//   width_valid  FIFO non-empty
//   width_ready  consumer accepts head
//   overflow     sticky: a width was dropped because the FIFO was full
//   done_out     NUM_PULSES pulses measured
module pulse_capture #(
  parameter int unsigned NUM_BITS   = 9,
  parameter int unsigned NUM_PULSES = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pulse_in,
  output logic [NUM_BITS-1:0] width_data,
  output logic                width_valid,
  input  logic                width_ready,
  output logic                overflow,
  output logic                done_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = (NUM_PULSES > 1) ? $clog2(NUM_PULSES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t              state;
  logic                p;
  logic                p_d;
  logic [NUM_BITS-1:0] counter;
  logic [CNT_W-1:0]    pulse_cnt;

  logic                rise_c;
  logic                push_c;
  logic                start_clr_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  // Input sampling: optional synchronizer, then one delay for edge detect.
`ifdef PULSE_CAPTURE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], pulse_in};
  end
  assign p = sync_q[1];
`else
  assign p = pulse_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_d <= 1'b0;
    else       p_d <= p;
  end

  assign rise_c      = p & ~p_d;
  assign push_c      = (state == S_MEASURE) & ~stop & ~p;
  assign start_clr_c = start & ~stop & ((state == S_IDLE) | (state == S_DONE));
  assign cnt_inc_c   = pulse_cnt + CNT_W'(1);

  // Measurement FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      counter   <= '0;
      pulse_cnt <= '0;
      done_out  <= 1'b0;
    end else if (stop) begin
      // Abort: any partial measurement is simply abandoned.
      state    <= S_IDLE;
      done_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pulse_cnt <= '0;
            if (NUM_PULSES == 0) begin
              state    <= S_DONE;
              done_out <= 1'b1;
            end else begin
              state    <= S_ARMED;
              done_out <= 1'b0;
            end
          end
        end
        S_ARMED: begin
          // Edge-qualified so a pulse already high on entry is skipped.
          if (rise_c) begin
            state   <= S_MEASURE;
            counter <= NUM_BITS'(1);
          end
        end
        S_MEASURE: begin
          if (p) begin
            if (counter != '1) counter <= counter + NUM_BITS'(1);
          end else begin
            pulse_cnt <= cnt_inc_c;
            if (cnt_inc_c == CNT_W'(NUM_PULSES)) begin
              state    <= S_DONE;
              done_out <= 1'b1;
            end else begin
              state <= S_ARMED;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Width FIFO: extra pointer bit separates full from empty.
  logic [NUM_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic                full_c;
  logic                pop_c;
  logic                wr_en_c;
  logic                drop_c;
  logic [PTR_W:0]      wr_nxt_c;
  logic [PTR_W:0]      rd_nxt_c;

  assign full_c   = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &
                    (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign pop_c    = width_valid & width_ready;
  assign wr_en_c  = push_c & (~full_c | pop_c);
  assign drop_c   = push_c & full_c & ~pop_c;
  assign wr_nxt_c = wr_ptr + (PTR_W + 1)'(wr_en_c);
  assign rd_nxt_c = rd_ptr + (PTR_W + 1)'(pop_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      width_valid <= 1'b0;
      width_data  <= '0;
    end else begin
      if (wr_en_c) mem[wr_ptr[PTR_W-1:0]] <= counter;
      wr_ptr      <= wr_nxt_c;
      rd_ptr      <= rd_nxt_c;
      width_valid <= (wr_nxt_c != rd_nxt_c);
      // Registered head: take the incoming word when it lands at the new head.
      if (wr_en_c && (wr_ptr[PTR_W-1:0] == rd_nxt_c[PTR_W-1:0]))
        width_data <= counter;
      else
        width_data <= mem[rd_nxt_c[PTR_W-1:0]];
    end
  end

  // Sticky overflow, cleared when a new run is armed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overflow <= 1'b0;
    else if (start_clr_c) overflow <= 1'b0;
    else if (drop_c)      overflow <= 1'b1;
  end

endmodule

// File: doc/pulse_capture.md
# pulse_capture

Receive-side counterpart of the pulse controller. It measures the high-time, in clock cycles, of each pulse on `pulse_in` and buffers the widths in a small show-ahead FIFO. A downstream consumer, normally the UART TX framer, drains the FIFO through a valid/ready handshake. `done_out` asserts once `NUM_PULSES` pulses have been measured, so a PC-side test can compare generated and measured widths.

## Interface
Parameters:
- `NUM_BITS`, 9: width of a measured value; counter saturates at 2^NUM_BITS-1
- `NUM_PULSES`, 10: pulses to measure before `done_out`
- `FIFO_DEPTH`, 4: width buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  arm a measurement run
- `stop`  in  1  abort run, return to IDLE
- `pulse_in`  in  1  pulse under measurement
- `width_data`  out  NUM_BITS  FIFO head (measured width)
- `width_valid`  out  1  FIFO non-empty
- `width_ready`  in  1  consumer accepts head
- `overflow`  out  1  sticky: a width was dropped because the FIFO was full
- `done_out`  out  1  `NUM_PULSES` pulses measured

## Operation
- Sampled signal `p`: `pulse_in` after the optional synchronizer (see Configuration). `p_d` is `p` registered once; a rising edge is `p & !p_d`.
- States:
  - IDLE: wait for `start`.
  - ARMED: wait for a rising edge of `p`.
  - MEASURE: count cycles while `p`=1.
  - DONE: idle with `done_out`=1.
- IDLE:
  - `start`=1 → clear pulse count, `done_out` and `overflow`.
  - Then go to DONE if `NUM_PULSES`=0, else go to ARMED.
- ARMED: rising edge → MEASURE, counter ← 1. A pulse already high when the block enters ARMED is ignored until it falls and rises again.
- MEASURE:
  - Edge with `p`=1 → counter ← counter+1, saturating at all-ones.
  - Edge with `p`=0 → push counter, pulse count +1.
  - Next state is DONE if the count reaches `NUM_PULSES`, else ARMED.
- DONE:
  - `done_out` held 1.
  - Further pulses are ignored.
  - `start` re-arms exactly as from IDLE.
- `stop`:
  - In any state → IDLE next edge.
  - An in-progress measurement is discarded, with no push and no count.
  - `done_out` clears.
  - FIFO contents and `overflow` are kept.
  - `stop` wins over a simultaneous `start`.
- `start` while in ARMED or MEASURE is ignored.
- FIFO behaviour:
  - Show-ahead: `width_valid`=!empty and `width_data`=head.
  - Pop on `width_valid & width_ready`.
  - Push while full with no pop in the same cycle → entry dropped, `overflow` ← 1. The dropped pulse still counts toward `NUM_PULSES`.
  - Push and pop in the same cycle while full → push accepted, occupancy unchanged.
  - Push and pop in the same cycle while empty → no bypass. Valid rises next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. An extra bit distinguishes full from empty.

## Timing
- Reset values:
  - `width_valid`=0, `width_data`=0, `overflow`=0, `done_out`=0.
  - State IDLE, FIFO empty, synchronizer and `p_d` = 0.
- Pulse with `p`=1 at N consecutive edges → measured width N (1 ≤ N < 2^NUM_BITS). Longer pulses report 2^NUM_BITS-1. Width 0 is never produced.
- Push occurs at the first edge with `p`=0. `width_valid` is visible from the following cycle.
- `pulse_in` → `p` latency is 0 cycles without the synchronizer and 2 cycles with it. Measured widths are identical in both cases.
- `done_out` rises in the same cycle as the final push becomes visible.
- Back-to-back pulses are allowed. A single low edge between pulses is enough: that edge pushes, the block enters ARMED, and the next rising edge starts the next measurement.
- `width_ready` may be held high permanently: one pop per cycle.

## Configuration
- `PULSE_CAPTURE_SYNC_EN`:
  - Defined: `pulse_in` passes through a 2-flop synchronizer before `p`, so asynchronous sources (external pin) are safe.
  - Undefined: `p` = `pulse_in` directly. `pulse_in` must be synchronous to `clk`, e.g. driven by the on-chip pulse controller.

## Test plan
- `start`, then pulses of 5, 1, 300 cycles with `width_ready`=1 → widths 5, 1, 300 in order. No overflow.
- `NUM_BITS`=4 and a 40-cycle pulse → width 15 (saturated). Next 3-cycle pulse → 3.
- `width_ready`=0, `FIFO_DEPTH`=4, six pulses → 4 entries held, `overflow`=1. Draining then returns the first four widths.
- `NUM_PULSES`=3, then 3 pulses → `done_out` rises with the third push. A 4th pulse produces no entry. `start` clears `done_out`.
- `stop` asserted mid-pulse (after 7 high cycles) → no push, IDLE, count unchanged. `start` together with `stop` → stays IDLE.
- `reset` asserted mid-MEASURE with 2 entries queued → all outputs 0 immediately (asynchronous), FIFO empty after release.
